// File: rtl/alu_cmd_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the ALU command sequencer.
package alu_cmd_pkg;

  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned OW_DEF      = 4;
  localparam int unsigned AW_DEF      = 3;
  localparam int unsigned ALU_LAT_DEF = 1;

  localparam logic [3:0] OPC_LDI  = 4'h0;
  localparam logic [3:0] OPC_ZERO = 4'h1;
  localparam logic [3:0] OPC_ADD  = 4'h2;
  localparam logic [3:0] OPC_SUB  = 4'h3;
  localparam logic [3:0] OPC_XOR  = 4'h4;
  localparam logic [3:0] OPC_AND  = 4'h5;
  localparam logic [3:0] OPC_OR   = 4'h6;
  localparam logic [3:0] OPC_LAND = 4'h7;
  localparam logic [3:0] OPC_LOR  = 4'h8;
  localparam logic [3:0] OPC_INC  = 4'h9;
  localparam logic [3:0] OPC_DEC  = 4'hA;
  localparam logic [3:0] OPC_SHL  = 4'hB;
  localparam logic [3:0] OPC_SHR  = 4'hC;
  localparam logic [3:0] OPC_LNOT = 4'hD;
  localparam logic [3:0] OPC_NOT  = 4'hE;
  localparam logic [3:0] OPC_DBL  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_regfile.sv
// Operand register file: 2**AW x DW, two async read ports, one sync write port, async active-low clear.
module alu_cmd_regfile
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues commands to an ALU of fixed latency and returns write-back results on a valid/ready port.
// Optional RES_ZF/RES_NF result flags are enabled by defining ALU_CMD_SEQUENCER_FLAGS_EN.
module alu_cmd_sequencer
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned OW      = OW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned ALU_LAT = ALU_LAT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [OW-1:0] CMD_OPC,
  input  logic [AW-1:0] CMD_DST,
  input  logic [AW-1:0] CMD_SRA,
  input  logic [AW-1:0] CMD_SRB,
  input  logic [DW-1:0] CMD_IMM,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [AW-1:0] RES_DST,
  output logic [DW-1:0] RES_DATA,
  output logic          ALU_ENA,
  output logic [OW-1:0] ALU_OPT,
  output logic [DW-1:0] ALU_RGA,
  output logic [DW-1:0] ALU_RGB,
  input  logic [DW-1:0] ALU_RGZ,
  output logic          BUSY
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
  ,
  output logic          RES_ZF,
  output logic          RES_NF
`endif
);

  localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t        r_state, w_state_nxt;
  logic          r_rdy_en;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_opt;
  logic [AW-1:0] r_dst;
  logic [DW-1:0] r_rga, r_rgb;
  logic          r_res_valid;
  logic [AW-1:0] r_res_dst;
  logic [DW-1:0] r_res_data;
  logic          w_accept, w_ldi, w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata, w_rd_a, w_rd_b;

  alu_cmd_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (CMD_SRA),
    .i_raddr_b (CMD_SRB),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // r_rdy_en keeps CMD_READY low until the first edge after reset release.
  assign CMD_READY = (r_state == ST_IDLE) && r_rdy_en;
  assign ALU_ENA   = (r_state == ST_EXEC);
  assign ALU_OPT   = ALU_ENA ? r_opt : '0;
  assign ALU_RGA   = r_rga;
  assign ALU_RGB   = r_rgb;
  assign BUSY      = (r_state != ST_IDLE);
  assign RES_VALID = r_res_valid;
  assign RES_DST   = r_res_dst;
  assign RES_DATA  = r_res_data;
  assign w_ldi     = (CMD_OPC == OW'(OPC_LDI));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_we        = 1'b0;
    w_waddr     = CMD_DST;
    w_wdata     = CMD_IMM;
    case (r_state)
      ST_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          w_accept = 1'b1;
          if (w_ldi) begin
            w_we        = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_we        = 1'b1;
          w_waddr     = r_dst;
          w_wdata     = ALU_RGZ;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RES_READY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rdy_en    <= 1'b0;
      r_cnt       <= '0;
      r_opt       <= '0;
      r_dst       <= '0;
      r_rga       <= '0;
      r_rgb       <= '0;
      r_res_valid <= 1'b0;
      r_res_dst   <= '0;
      r_res_data  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_opt <= CMD_OPC;
        r_dst <= CMD_DST;
        r_rga <= w_rd_a;
        r_rgb <= w_rd_b;
        r_cnt <= CW'(ALU_LAT);
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_we) begin
        r_res_valid <= 1'b1;
        r_res_dst   <= w_waddr;
        r_res_data  <= w_wdata;
      end else if (r_state == ST_RESP && RES_READY) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
  logic r_zf, r_nf;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_zf <= 1'b0;
      r_nf <= 1'b0;
    end else if (w_we) begin
      r_zf <= (w_wdata == '0);
      r_nf <= w_wdata[DW-1];
    end
  end

  assign RES_ZF = r_zf;
  assign RES_NF = r_nf;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench: one sequencer with a 1-stage ALU model, one with a 3-stage model.
module tb_alu_cmd_sequencer;
  import alu_cmd_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] opc = '0;
  logic [2:0] dst = '0, sra = '0, srb = '0;
  logic [7:0] imm = '0;

  logic       d1_cmd_ready, d1_res_valid, d1_ena, d1_busy;
  logic [2:0] d1_res_dst;
  logic [7:0] d1_res_data, d1_rga, d1_rgb, d1_rgz;
  logic [3:0] d1_opt;
  logic       d3_cmd_ready, d3_res_valid, d3_ena, d3_busy;
  logic [2:0] d3_res_dst;
  logic [7:0] d3_res_data, d3_rga, d3_rgb, d3_rgz, p1, p2;
  logic [3:0] d3_opt;
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
  logic d1_zf, d1_nf, d3_zf, d3_nf, res_zf, res_nf;
  assign res_zf = sel ? d3_zf : d1_zf;
  assign res_nf = sel ? d3_nf : d1_nf;
`endif

  logic       cmd_ready, res_valid, alu_ena, busy;
  logic [2:0] res_dst;
  logic [7:0] res_data, alu_rga, alu_rgb;
  logic [3:0] alu_opt;
  assign cmd_ready = sel ? d3_cmd_ready : d1_cmd_ready;
  assign res_valid = sel ? d3_res_valid : d1_res_valid;
  assign res_dst   = sel ? d3_res_dst   : d1_res_dst;
  assign res_data  = sel ? d3_res_data  : d1_res_data;
  assign alu_ena   = sel ? d3_ena       : d1_ena;
  assign alu_opt   = sel ? d3_opt       : d1_opt;
  assign alu_rga   = sel ? d3_rga       : d1_rga;
  assign alu_rgb   = sel ? d3_rgb       : d1_rgb;
  assign busy      = sel ? d3_busy      : d1_busy;

  alu_cmd_sequencer #(.DW(8), .OW(4), .AW(3), .ALU_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(cmd_valid & ~sel), .CMD_READY(d1_cmd_ready),
    .CMD_OPC(opc), .CMD_DST(dst), .CMD_SRA(sra), .CMD_SRB(srb), .CMD_IMM(imm),
    .RES_VALID(d1_res_valid), .RES_READY(res_ready & ~sel),
    .RES_DST(d1_res_dst), .RES_DATA(d1_res_data),
    .ALU_ENA(d1_ena), .ALU_OPT(d1_opt), .ALU_RGA(d1_rga), .ALU_RGB(d1_rgb),
    .ALU_RGZ(d1_rgz), .BUSY(d1_busy)
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    , .RES_ZF(d1_zf), .RES_NF(d1_nf)
`endif
  );

  alu_cmd_sequencer #(.DW(8), .OW(4), .AW(3), .ALU_LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(cmd_valid & sel), .CMD_READY(d3_cmd_ready),
    .CMD_OPC(opc), .CMD_DST(dst), .CMD_SRA(sra), .CMD_SRB(srb), .CMD_IMM(imm),
    .RES_VALID(d3_res_valid), .RES_READY(res_ready & sel),
    .RES_DST(d3_res_dst), .RES_DATA(d3_res_data),
    .ALU_ENA(d3_ena), .ALU_OPT(d3_opt), .ALU_RGA(d3_rga), .ALU_RGB(d3_rgb),
    .ALU_RGZ(d3_rgz), .BUSY(d3_busy)
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    , .RES_ZF(d3_zf), .RES_NF(d3_nf)
`endif
  );

  function automatic logic [7:0] alu_f(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      OPC_ADD: return a + b;
      OPC_SUB: return a - b;
      OPC_XOR: return a ^ b;
      OPC_INC: return a + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge CLK) d1_rgz <= alu_f(d1_opt, d1_rga, d1_rgb);
  always @(posedge CLK) begin
    p1     <= alu_f(d3_opt, d3_rga, d3_rgb);
    p2     <= p1;
    d3_rgz <= p2;
  end

  task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [7:0] i);
    int n = 0;
    opc = o; dst = d; sra = a; srb = b; imm = i;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin @(posedge CLK); #1; n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL issue_wait cmd_ready=%b required 1", cmd_ready); end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  // edges counted after the accept edge until RES_VALID is seen; ena counts ALU_ENA-high cycles
  task automatic wait_res(output int edges, output int ena);
    edges = 0; ena = 0;
    while (!res_valid && edges < 12) begin
      if (alu_ena) ena++;
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL handshake_drop res_valid=%b required 0", res_valid); end
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [7:0] i, input int exp_edges, input logic [7:0] exp_data);
    int e, n;
    issue(o, d, a, b, i);
    wait_res(e, n);
    checks++;
    if (e !== exp_edges) begin errors++; $display("FAIL %s_latency edges=%0d required %0d", nm, e, exp_edges); end
    checks++;
    if (res_data !== exp_data) begin errors++; $display("FAIL %s_data got %h required %h", nm, res_data, exp_data); end
    checks++;
    if (res_dst !== d) begin errors++; $display("FAIL %s_dst got %0d required %0d", nm, res_dst, d); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready, res_valid, busy, alu_ena, alu_opt, res_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b vld=%b busy=%b ena=%b opt=%h data=%h required all 0",
               cmd_ready, res_valid, busy, alu_ena, alu_opt, res_data);
    end
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", cmd_ready); end
  endtask

  task automatic test_ldi();
    run_op("ldi_r1", OPC_LDI, 3'd1, 3'd0, 3'd0, 8'h05, 0, 8'h05);
    checks++;
    if (alu_ena !== 1'b0) begin errors++; $display("FAIL ldi_ena got %b required 0", alu_ena); end
    handshake();
    run_op("ldi_r2", OPC_LDI, 3'd2, 3'd0, 3'd0, 8'h06, 0, 8'h06);
    handshake();
  endtask

  task automatic test_add();
    int e, n;
    issue(OPC_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    checks++;
    if ({alu_ena, alu_opt, alu_rga, alu_rgb} !== {1'b1, OPC_ADD, 8'h05, 8'h06}) begin
      errors++;
      $display("FAIL add_issue ena=%b opt=%h rga=%h rgb=%h required 1 2 05 06", alu_ena, alu_opt, alu_rga, alu_rgb);
    end
    wait_res(e, n);
    checks++;
    if (e !== 2 || n !== 2) begin errors++; $display("FAIL add_timing edges=%0d ena_cycles=%0d required 2 2", e, n); end
    checks++;
    if ({res_data, res_dst} !== {8'h0B, 3'd3}) begin
      errors++; $display("FAIL add_result data=%h dst=%0d required 0b 3", res_data, res_dst);
    end
    checks++;
    if ({alu_ena, alu_opt} !== 5'b0) begin errors++; $display("FAIL add_resp_idle ena=%b opt=%h required 0 0", alu_ena, alu_opt); end
    handshake();
  endtask

  task automatic test_sub_xor();
    run_op("ldi_r1b", OPC_LDI, 3'd1, 3'd0, 3'd0, 8'h02, 0, 8'h02); handshake();
    run_op("ldi_r2b", OPC_LDI, 3'd2, 3'd0, 3'd0, 8'h03, 0, 8'h03); handshake();
    run_op("sub", OPC_SUB, 3'd4, 3'd1, 3'd2, 8'h00, 2, 8'hFF);
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    checks++;
    if ({res_nf, res_zf} !== 2'b10) begin errors++; $display("FAIL sub_flags nf=%b zf=%b required 1 0", res_nf, res_zf); end
`endif
    handshake();
    run_op("xor", OPC_XOR, 3'd6, 3'd4, 3'd4, 8'h00, 2, 8'h00);
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    checks++;
    if ({res_nf, res_zf} !== 2'b01) begin errors++; $display("FAIL xor_flags nf=%b zf=%b required 0 1", res_nf, res_zf); end
`endif
    handshake();
    run_op("add_dst_eq_sra", OPC_ADD, 3'd1, 3'd1, 3'd2, 8'h00, 2, 8'h05); handshake();
    run_op("add_readback", OPC_ADD, 3'd7, 3'd1, 3'd1, 8'h00, 2, 8'h0A); handshake();
  endtask

  task automatic test_backpressure();
    run_op("bp_ldi", OPC_LDI, 3'd7, 3'd0, 3'd0, 8'hA5, 0, 8'hA5);
    opc = OPC_LDI; dst = 3'd6; imm = 8'h3C; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({res_valid, res_data, res_dst, cmd_ready} !== {1'b1, 8'hA5, 3'd7, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d vld=%b data=%h dst=%0d rdy=%b required 1 a5 7 0", i, res_valid, res_data, res_dst, cmd_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_idle_cycle vld=%b rdy=%b required 0 1", res_valid, cmd_ready);
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({res_valid, res_data, res_dst} !== {1'b1, 8'h3C, 3'd6}) begin
      errors++; $display("FAIL bp_next vld=%b data=%h dst=%0d required 1 3c 6", res_valid, res_data, res_dst);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(OPC_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({res_valid, alu_ena, busy, cmd_ready} !== 4'b0) begin
      errors++; $display("FAIL rst_exec vld=%b ena=%b busy=%b rdy=%b required 0 0 0 0", res_valid, alu_ena, busy, cmd_ready);
    end
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    run_op("rst_ldi", OPC_LDI, 3'd3, 3'd0, 3'd0, 8'h77, 0, 8'h77);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy} !== 2'b0) begin errors++; $display("FAIL rst_resp vld=%b busy=%b required 0 0", res_valid, busy); end
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    run_op("rst_cleared", OPC_ADD, 3'd5, 3'd1, 3'd2, 8'h00, 2, 8'h00);
    handshake();
  endtask

  task automatic test_lat3();
    int e, n;
    sel = 1'b1;
    run_op("lat3_ldi", OPC_LDI, 3'd1, 3'd0, 3'd0, 8'h7F, 0, 8'h7F); handshake();
    issue(OPC_INC, 3'd2, 3'd1, 3'd0, 8'h00);
    checks++;
    if ({alu_ena, alu_opt, alu_rga} !== {1'b1, OPC_INC, 8'h7F}) begin
      errors++; $display("FAIL lat3_issue ena=%b opt=%h rga=%h required 1 9 7f", alu_ena, alu_opt, alu_rga);
    end
    wait_res(e, n);
    checks++;
    if (e !== 4 || n !== 4) begin errors++; $display("FAIL lat3_timing edges=%0d ena_cycles=%0d required 4 4", e, n); end
    checks++;
    if ({res_data, res_dst} !== {8'h80, 3'd2}) begin
      errors++; $display("FAIL lat3_result data=%h dst=%0d required 80 2", res_data, res_dst);
    end
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    checks++;
    if ({res_nf, res_zf} !== 2'b10) begin errors++; $display("FAIL lat3_flags nf=%b zf=%b required 1 0", res_nf, res_zf); end
`endif
    handshake();
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_sub_xor();
    test_backpressure();
    test_reset_mid();
    test_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
